segment_spi_main: RTL

SPI main (initiator) that drives the motion-segment SPI link from the host side: it polls the secondary's free-slot count with `beagleg::CMD_STATUS` and streams motion segments with `beagleg::CMD_WRITE_FIFO`, never sending more segments than the secondary has reported free. It sits between a local segment source (valid/ready) and the four SPI pins. It is used both as the FPGA-to-FPGA feeder and as the bench driver for the receiving top level.

---
 rtl/segment_spi_main.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/segment_spi_main.sv
// SPI initiator for the motion-segment link: polls free slots with CMD_STATUS and
// streams one segment per CMD_WRITE_FIFO transaction, never exceeding the reported credit.

package beagleg;
    localparam int unsigned MotionSegmentBits = 64;
    localparam logic [7:0]  CMD_STATUS        = 8'h01;
    localparam logic [7:0]  CMD_WRITE_FIFO    = 8'h02;
endpackage

module segment_spi_main #(
    parameter int unsigned ClkDiv       = 4,
    parameter int unsigned SegmentBytes = beagleg::MotionSegmentBits / 8,
    parameter int unsigned CsGap        = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        seg_valid,
    output logic                        seg_ready,
    input  logic [8*SegmentBytes-1:0]   seg_data,
    input  logic                        status_req,
    output logic                        spi_sck,
    output logic                        spi_mosi,
    input  logic                        spi_miso,
    output logic                        spi_cs,
    output logic [7:0]                  free_slots,
    output logic                        busy
);

    localparam int unsigned SegW   = 8 * SegmentBytes;
    localparam int unsigned CntMax = (ClkDiv > CsGap) ? ClkDiv : CsGap;
    localparam int unsigned CntW   = $clog2(CntMax + 1);
    localparam int unsigned ByteW  = $clog2(SegmentBytes + 2);
    localparam logic [ByteW-1:0] LastWrite  = ByteW'(SegmentBytes);
    localparam logic [ByteW-1:0] LastStatus = ByteW'(1);
    localparam logic [7:0] CmdStatus = beagleg::CMD_STATUS;
    localparam logic [7:0] CmdWrite  = beagleg::CMD_WRITE_FIFO;

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        SHIFT,
        CS_HOLD,
        GAP
    } state_t;

    state_t            state;
    logic [CntW-1:0]   cnt;
    logic [2:0]        bit_cnt;
    logic [ByteW-1:0]  byte_cnt;
    logic              is_write;
    logic              pend;
    logic [7:0]        tx_sh;
    logic [7:0]        rx_sh;
    logic [SegW-1:0]   seg_buf;

    logic half_done;
    logic gap_done;
    logic last_byte;

    assign half_done = (cnt == CntW'(ClkDiv - 1));
    assign gap_done  = (cnt == CntW'(CsGap - 1));
    assign last_byte = (byte_cnt == (is_write ? LastWrite : LastStatus));

    // Transaction sequencer; seg_buf drains one byte per loaded payload byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_cnt    <= '0;
            byte_cnt   <= '0;
            is_write   <= 1'b0;
            pend       <= 1'b0;
            tx_sh      <= '0;
            rx_sh      <= '0;
            seg_buf    <= '0;
            seg_ready  <= 1'b0;
            spi_sck    <= 1'b0;
            spi_mosi   <= 1'b0;
            spi_cs     <= 1'b1;
            free_slots <= '0;
            busy       <= 1'b0;
        end else begin
            if (status_req) pend <= 1'b1;
            case (state)
                IDLE: begin
                    cnt      <= '0;
                    bit_cnt  <= '0;
                    byte_cnt <= '0;
                    if (seg_valid && seg_ready) begin
                        seg_buf   <= seg_data;
                        is_write  <= 1'b1;
                        tx_sh     <= CmdWrite;
                        spi_mosi  <= CmdWrite[7];
                        spi_cs    <= 1'b0;
                        busy      <= 1'b1;
                        seg_ready <= 1'b0;
                        state     <= CS_SETUP;
                    end else if (pend || status_req || (seg_valid && free_slots == 8'd0)) begin
                        seg_buf   <= '0;
                        is_write  <= 1'b0;
                        tx_sh     <= CmdStatus;
                        spi_mosi  <= CmdStatus[7];
                        spi_cs    <= 1'b0;
                        busy      <= 1'b1;
                        seg_ready <= 1'b0;
                        pend      <= 1'b0;
                        state     <= CS_SETUP;
                    end else begin
                        seg_ready <= (free_slots != 8'd0);
                    end
                end
                CS_SETUP: begin
                    cnt <= cnt + CntW'(1);
                    if (half_done) begin
                        cnt     <= '0;
                        spi_sck <= 1'b1;
                        rx_sh   <= {rx_sh[6:0], spi_miso};
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    cnt <= cnt + CntW'(1);
                    if (half_done) begin
                        cnt <= '0;
                        if (spi_sck) begin
                            // Falling edge: present the next bit, or the next byte's MSB.
                            spi_sck <= 1'b0;
                            if (bit_cnt != 3'd7) begin
                                tx_sh    <= {tx_sh[6:0], 1'b0};
                                spi_mosi <= tx_sh[6];
                            end else if (!last_byte) begin
                                tx_sh    <= seg_buf[7:0];
                                spi_mosi <= seg_buf[7];
                                seg_buf  <= seg_buf >> 8;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) byte_cnt <= byte_cnt + ByteW'(1);
                            if (bit_cnt == 3'd7 && last_byte) begin
                                state <= CS_HOLD;
                            end else begin
                                spi_sck <= 1'b1;
                                rx_sh   <= {rx_sh[6:0], spi_miso};
                            end
                        end
                    end
                end
                CS_HOLD: begin
                    cnt <= cnt + CntW'(1);
                    if (half_done) begin
                        cnt      <= '0;
                        spi_cs   <= 1'b1;
                        spi_mosi <= 1'b0;
                        state    <= GAP;
                        if (!is_write) begin
                            free_slots <= rx_sh;
                        end else if (free_slots != 8'd0) begin
                            free_slots <= free_slots - 8'd1;
                        end
                    end
                end
                GAP: begin
                    cnt <= cnt + CntW'(1);
                    if (gap_done) begin
                        cnt       <= '0;
                        busy      <= 1'b0;
                        seg_ready <= (free_slots != 8'd0);
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
